regfile_mp: RTL
===============

Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the decode stage, generalising the single-write/two-read file to configurable width, depth and port counts.
- Writes are synchronous on clk; reads are combinational, with same-cycle write-through bypass from any write port.
- Register 0 is hardwired to zero.
- Feeds operand values to the id/ex pipeline register and accepts writebacks from the forwarding/writeback path.

Parameters:
XLEN, 32, data width of each register in bits
NREG, 32, number of architectural registers (power of two, >= 2)
NRD, 2, number of read ports
NWR, 1, number of write ports
AW, $clog2(NREG), register address width (derived; not to be overridden)

Ports:
clk  input  1  clock, rising edge active
rst  input  1  reset, asynchronous, active-high
rd_addr  input  NRD*AW  read addresses; port k at bits [k*AW +: AW]
rd_data  output  NRD*XLEN  read data; port k at bits [k*XLEN +: XLEN]
wr_en  input  NWR  per-port write enable
wr_addr  input  NWR*AW  write addresses; port j at bits [j*AW +: AW]
wr_data  input  NWR*XLEN  write data; port j at bits [j*XLEN +: XLEN]
alloc_en  input  1  scoreboard: mark destination busy (REGFILE_SCOREBOARD_EN only; ignored otherwise)
alloc_addr  input  AW  scoreboard destination register
rd_busy  output  NRD  per-read-port pending-write flag (constant 0 without REGFILE_SCOREBOARD_EN)

Behaviour:
Reset
- While rst is high, asynchronously: all NREG registers = 0, all busy bits = 0.
- rd_data is combinational, so it reads 0 during reset; rd_busy = 0.
- Reset asserted mid-write: the write is discarded.

Write
- On posedge clk with rst low, each port j with wr_en[j]=1 and wr_addr_j != 0 writes wr_data_j.
- Writes to register 0 are dropped.
- Several ports writing the same address in one cycle: the highest-index port wins.

Read
- rd_data_k = 0 if rd_addr_k == 0.
- Otherwise, if any enabled write port targets rd_addr_k in the current cycle, rd_data_k = that port's wr_data (highest index wins). This is the same-cycle bypass, with zero latency.
- Otherwise rd_data_k = stored value.
- Read-to-data latency: 0 cycles (combinational). Write-to-storage: 1 clk edge.
- Reads of unwritten registers after reset return 0.

Arithmetic and sizing
- No arithmetic is performed.
- Addresses are always in range because NREG = 2^AW.
- The storage array is an explicit clocked block. No latch inference: every read path must be fully assigned.

Optional Feature:
Macro: REGFILE_SCOREBOARD_EN

With the macro defined, a per-register busy vector (NREG bits) is built:
- Set: on posedge clk, if alloc_en=1 and alloc_addr != 0, busy[alloc_addr] <= 1.
- Clear: on posedge clk, any committed write (wr_en, addr != 0) clears busy[wr_addr].
- Simultaneous alloc and write to the same register: alloc wins and busy stays 1, because the new producer supersedes the old one.
- busy[0] is always 0.
- rd_busy_k = busy[rd_addr_k] AND NOT (any enabled write to rd_addr_k this cycle), since bypassed data is valid.
- An alloc in the current cycle does not affect rd_busy until the next cycle.

Without the macro: no busy storage is built, rd_busy is tied to 0, and alloc_en/alloc_addr are unused.

Test Plan:
1. Reset and zero register: assert rst for 3 cycles, release. Read regs 0, 5 and 31 → all 0. Write x0=0xDEADBEEF, read x0 → 0.
2. Basic write/read: write x7=0x12345678, next cycle read x7 on port 0 and port 1 → 0x12345678 on both.
3. Same-cycle bypass: x9 holds 0xAAAA0000; in one cycle write x9=0x5555FFFF and read x9 → 0x5555FFFF that cycle, and stored afterwards.
4. Write collision (NWR=2): port0 writes x3=0x1, port1 writes x3=0x2 in the same cycle. Bypass read → 0x2; next-cycle read → 0x2.
5. Async reset mid-stream: write x4=0xF0F0F0F0, then raise rst between clock edges → rd_data for x4 reads 0 immediately, and the value stays 0 after release.
6. Scoreboard (REGFILE_SCOREBOARD_EN):
   - alloc x10 → next cycle rd_busy=1 for x10.
   - Write x10=0x77 → rd_busy=0 in that same cycle (via bypass), and 0 thereafter.
   - alloc and write x11 in the same cycle → rd_busy for x11 is 1 next cycle.
   - alloc x0 → busy never set.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file for the decode stage.
// Synchronous writes on NWR ports, combinational reads on NRD ports with
// same-cycle write-through bypass; register 0 reads as zero.
// Optional feature: define REGFILE_SCOREBOARD_EN to build a per-register busy
// vector that flags reads of registers with an outstanding producer.
// No valid/ready handshakes here: every port is sampled or driven every cycle,
// a write is qualified only by its wr_en bit and alloc only by alloc_en.
module regfile_mp #(
   parameter  int XLEN = 32,
   parameter  int NREG = 32,
   parameter  int NRD  = 2,
   parameter  int NWR  = 1,
   localparam int AW   = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                alloc_en,
   input  logic [AW-1:0]       alloc_addr,
   output logic [NRD-1:0]      rd_busy
);

   logic [XLEN-1:0] regs [NREG];
   logic [AW-1:0]   wa   [NWR];
   logic [XLEN-1:0] wd   [NWR];
   logic [AW-1:0]   ra   [NRD];
   logic [NRD-1:0]  rd_hit;

   for (genvar j = 0; j < NWR; j++) begin : g_wr_unpack
      assign wa[j] = wr_addr[j*AW +: AW];
      assign wd[j] = wr_data[j*XLEN +: XLEN];
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd_unpack
      assign ra[k] = rd_addr[k*AW +: AW];
   end

   // Storage: clear on reset, then apply write ports in index order so the
   // highest-index port wins a same-address collision. Register 0 is never written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wa[j] != '0)) begin
               regs[wa[j]] <= wd[j];
            end
         end
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [XLEN-1:0] rd_val;
      logic            hit;

      // Read mux: stored value, overridden by any same-cycle write to the
      // same address (last port wins), forced to zero for x0 and during reset.
      always_comb begin
         rd_val = regs[ra[k]];
         hit    = 1'b0;
         for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wa[j] == ra[k])) begin
               rd_val = wd[j];
               hit    = 1'b1;
            end
         end
         if (rst || (ra[k] == '0)) begin
            rd_val = '0;
         end
      end

      assign rd_data[k*XLEN +: XLEN] = rd_val;
      assign rd_hit[k]               = hit;
   end

`ifdef REGFILE_SCOREBOARD_EN
   logic [NREG-1:0] busy;

   // Busy vector: committed writes clear, alloc sets afterwards so a new
   // producer allocated in the same cycle supersedes the retiring one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wa[j] != '0)) begin
               busy[wa[j]] <= 1'b0;
            end
         end
         if (alloc_en && (alloc_addr != '0)) begin
            busy[alloc_addr] <= 1'b1;
         end
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_busy
      // A bypassed read already carries the new value, so it is not busy.
      assign rd_busy[k] = busy[ra[k]] & ~rd_hit[k];
   end
`else
   logic unused_sb;

   // Scoreboard absent: alloc inputs and bypass hits have no consumer.
   assign unused_sb = ^{alloc_en, alloc_addr, rd_hit};
   assign rd_busy   = '0;
`endif

endmodule
